// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle.
// master : the fetch unit (drives pc and the IF/ID outputs, receives control and ins).
// slave  : the surrounding core / instruction memory.
// Signals:
//   start, stall, redirect, redirect_pc, halt : control into the fetch unit
//   pc, ins                                   : combinational instruction-memory port
//   if_ins, if_pc, if_valid                   : IF/ID register to the decoder
//   running, done                             : fetch state status
interface fetch_unit_if #(
    parameter int unsigned PCWIDTH  = 8,
    parameter int unsigned INSWIDTH = 16
);
    logic                start;
    logic                stall;
    logic                redirect;
    logic [PCWIDTH-1:0]  redirect_pc;
    logic                halt;
    logic [PCWIDTH-1:0]  pc;
    logic [INSWIDTH-1:0] ins;
    logic [INSWIDTH-1:0] if_ins;
    logic [PCWIDTH-1:0]  if_pc;
    logic                if_valid;
    logic                running;
    logic                done;

    modport master (
        input  start, stall, redirect, redirect_pc, halt, ins,
        output pc, if_ins, if_pc, if_valid, running, done
    );

    modport slave (
        output start, stall, redirect, redirect_pc, halt, ins,
        input  pc, if_ins, if_pc, if_valid, running, done
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the program counter, presents it to a combinational
// instruction memory and captures the returned word into the IF/ID register.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.master (control in, pc/ins memory port, IF/ID outputs, status)
// States: IDLE (wait for start), RUN (fetch), HALT (terminal until reset).
module fetch_unit #(
    parameter int unsigned         PCWIDTH  = 8,
    parameter int unsigned         INSWIDTH = 16,
    parameter int unsigned         CODESIZE = 8,
    parameter logic [PCWIDTH-1:0]  RESET_PC = '0,
    parameter logic [INSWIDTH-1:0] NOP_INS  = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    // One extra bit so CODESIZE == 2**PCWIDTH is representable; the check then never fires
    // and pc wraps naturally.
    localparam logic [PCWIDTH:0]   CodeLimit = (PCWIDTH + 1)'(CODESIZE);
    localparam logic [PCWIDTH-1:0] PcOne     = PCWIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e              state_q, state_d;
    logic [PCWIDTH-1:0]  pc_q, pc_d;
    logic [INSWIDTH-1:0] if_ins_q, if_ins_d;
    logic [PCWIDTH-1:0]  if_pc_q, if_pc_d;
    logic                if_valid_q, if_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            if_ins_q   <= NOP_INS;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_ins_q   <= if_ins_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_ins_d   = if_ins_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;

        unique case (state_q)
            StIdle: begin
                if_valid_d = 1'b0;
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.halt) begin
                    state_d    = StHalt;
                    if_valid_d = 1'b0;
                    if_ins_d   = NOP_INS;
                end else if (bus.redirect) begin
                    // Wrong-path word at pc is dropped; if_pc records where the flush happened.
                    pc_d       = bus.redirect_pc;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b0;
                    if_ins_d   = NOP_INS;
                end else if (bus.stall) begin
                    // Hold everything.
                end else if ({1'b0, pc_q} >= CodeLimit) begin
                    state_d    = StHalt;
                    if_valid_d = 1'b0;
                    if_ins_d   = NOP_INS;
                end else begin
                    if_ins_d   = bus.ins;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + PcOne;
                end
            end
            StHalt: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d    = StIdle;
                if_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.if_ins   = if_ins_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.if_valid = if_valid_q;
    assign bus.running  = (state_q == StRun);
    assign bus.done     = (state_q == StHalt);

endmodule
